// File: rtl/iterative_alu.sv
// iterative_alu: multi-cycle ALU with iterative shifts and an optional
// radix-2 shift-add multiplier, valid/ready handshakes on both sides.
//
// Parameters:
//   XLEN       operand/result width (power of two, >= 8)
//   SHIFT_STEP bits shifted per BUSY cycle (power of two, 1..XLEN)
// Build option:
//   ITERATIVE_ALU_MUL_EN  defined -> MUL (4'b1000) implemented;
//                         undefined -> MUL decodes as illegal.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready, op[3:0], a, b   request side
//   out_valid/out_ready, result, zero, illegal   response side
module iterative_alu #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SW = $clog2(XLEN);
    localparam logic [SW:0] STEP = (SW+1)'(SHIFT_STEP);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_SRA = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
`ifdef ITERATIVE_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_n;
    logic [3:0]      opr, opr_n;
    logic [XLEN-1:0] acc, acc_n;
    logic [SW-1:0]   rem, rem_n;
    logic [XLEN-1:0] res_n;
    logic            zero_n, ill_n;
`ifdef ITERATIVE_ALU_MUL_EN
    logic [XLEN-1:0] mcand, mcand_n;
    logic [XLEN-1:0] mplier, mplier_n;
    logic [SW-1:0]   cnt, cnt_n;
    logic            is_mul;
    assign is_mul = (op == OP_MUL);
`endif

    logic [SW-1:0] shamt;
    logic          is_sh;
    assign shamt = b[SW-1:0];
    assign is_sh = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

    // Single-cycle results from the live request operands.
    logic [XLEN-1:0] alu_v;
    logic            alu_ok;
    always_comb begin
        alu_v  = '0;
        alu_ok = 1'b1;
        case (op)
            OP_ADD:  alu_v = a + b;
            OP_SUB:  alu_v = a - b;
            OP_AND:  alu_v = a & b;
            OP_OR:   alu_v = a | b;
            OP_SLT:  alu_v = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            default: alu_ok = 1'b0;
        endcase
    end

    // One shift step: min(SHIFT_STEP, remaining). The arithmetic shift
    // keeps re-copying the MSB, which is the original operand's sign.
    logic [SW:0]     amt;
    logic [XLEN-1:0] sh_v;
    always_comb begin
        amt = ({1'b0, rem} < STEP) ? {1'b0, rem} : STEP;
        case (opr)
            OP_SLL:  sh_v = acc << amt;
            OP_SRA:  sh_v = $unsigned($signed(acc) >>> amt);
            default: sh_v = acc >> amt;
        endcase
    end

    logic            fin;
    logic [XLEN-1:0] fin_res;
    logic            fin_ill;

    always_comb begin
        state_n  = state;
        opr_n    = opr;
        acc_n    = acc;
        rem_n    = rem;
        res_n    = result;
        zero_n   = zero;
        ill_n    = illegal;
        fin      = 1'b0;
        fin_res  = '0;
        fin_ill  = 1'b0;
`ifdef ITERATIVE_ALU_MUL_EN
        mcand_n  = mcand;
        mplier_n = mplier;
        cnt_n    = cnt;
`endif
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    opr_n = op;
                    unique case (1'b1)
                        alu_ok: begin
                            fin     = 1'b1;
                            fin_res = alu_v;
                        end
                        is_sh && (shamt == '0): begin
                            fin     = 1'b1;
                            fin_res = a;
                        end
                        is_sh && (shamt != '0): begin
                            acc_n   = a;
                            rem_n   = shamt;
                            state_n = BUSY;
                        end
`ifdef ITERATIVE_ALU_MUL_EN
                        is_mul: begin
                            acc_n    = '0;
                            mcand_n  = a;
                            mplier_n = b;
                            cnt_n    = '0;
                            state_n  = BUSY;
                        end
`endif
                        default: begin
                            fin     = 1'b1;
                            fin_ill = 1'b1;
                        end
                    endcase
                end
            end
            BUSY: begin
`ifdef ITERATIVE_ALU_MUL_EN
                if (opr == OP_MUL) begin
                    acc_n    = mplier[0] ? acc + mcand : acc;
                    mcand_n  = mcand << 1;
                    mplier_n = mplier >> 1;
                    cnt_n    = cnt + 1'b1;
                    if (cnt == '1) begin
                        fin     = 1'b1;
                        fin_res = acc_n;
                    end
                end else
`endif
                begin
                    acc_n = sh_v;
                    rem_n = rem - amt[SW-1:0];
                    if (rem_n == '0) begin
                        fin     = 1'b1;
                        fin_res = sh_v;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (fin) begin
            state_n = DONE;
            res_n   = fin_res;
            zero_n  = (fin_res == '0);
            ill_n   = fin_ill;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            opr     <= '0;
            acc     <= '0;
            rem     <= '0;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
`ifdef ITERATIVE_ALU_MUL_EN
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
`endif
        end else begin
            state   <= state_n;
            opr     <= opr_n;
            acc     <= acc_n;
            rem     <= rem_n;
            result  <= res_n;
            zero    <= zero_n;
            illegal <= ill_n;
`ifdef ITERATIVE_ALU_MUL_EN
            mcand   <= mcand_n;
            mplier  <= mplier_n;
            cnt     <= cnt_n;
`endif
        end
    end

    assign in_ready  = rst && (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: directed test of iterative_alu with SHIFT_STEP=1
// (main instance) and SHIFT_STEP=4 (second instance).
module tb_iterative_alu;

    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] AND = 4'b0010;
    localparam logic [3:0] OR  = 4'b0011;
    localparam logic [3:0] SRA = 4'b0100;
    localparam logic [3:0] SLT = 4'b0101;
    localparam logic [3:0] SLL = 4'b0110;
    localparam logic [3:0] SRL = 4'b0111;
    localparam logic [3:0] MUL = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, zero, illegal;
    logic [31:0] result;

    logic        v4 = 1'b0;
    logic        rdy4 = 1'b0;
    logic        in_ready4, out_valid4, zero4, illegal4;
    logic [31:0] result4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iterative_alu #(.XLEN(32), .SHIFT_STEP(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    iterative_alu #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(v4), .in_ready(in_ready4),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid4), .out_ready(rdy4),
        .result(result4), .zero(zero4), .illegal(illegal4)
    );

    // Issue one request to the STEP=1 instance, measure latency,
    // capture outputs, then complete the output handshake.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int lat,
                          output logic [31:0] r, output logic z,
                          output logic il);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        r = result; z = zero; il = illegal;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: got rdy=%b ov=%b, expected 0 0", in_ready, out_valid);
        end
        checks++;
        if (result !== 32'h0 || zero !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got r=%h z=%b il=%b, expected 0 0 0", result, zero, illegal);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_rdy: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_arith();
        int lat; logic [31:0] r; logic z, il;
        run_op(ADD, 32'h7FFFFFFF, 32'h1, lat, r, z, il);
        checks++;
        if (r !== 32'h80000000 || z !== 1'b0 || lat !== 1) begin
            errors++;
            $display("FAIL add: got r=%h z=%b lat=%0d, expected 80000000 0 1", r, z, lat);
        end
        run_op(SUB, 32'd5, 32'd5, lat, r, z, il);
        checks++;
        if (r !== 32'h0 || z !== 1'b1 || lat !== 1) begin
            errors++;
            $display("FAIL sub: got r=%h z=%b lat=%0d, expected 0 1 1", r, z, lat);
        end
        run_op(AND, 32'hF0F0_1234, 32'h0FF0_FF00, lat, r, z, il);
        checks++;
        if (r !== 32'h00F0_1200 || lat !== 1) begin
            errors++;
            $display("FAIL and: got r=%h lat=%0d, expected 00f01200 1", r, lat);
        end
        run_op(OR, 32'hF000_0001, 32'h0000_1000, lat, r, z, il);
        checks++;
        if (r !== 32'hF000_1001 || il !== 1'b0) begin
            errors++;
            $display("FAIL or: got r=%h il=%b, expected f0001001 0", r, il);
        end
    endtask

    task automatic test_shift();
        int lat; logic [31:0] r; logic z, il;
        run_op(SRA, 32'hFFFFFF6E, 32'd4, lat, r, z, il);
        checks++;
        if (r !== 32'hFFFFFFF6 || lat !== 5) begin
            errors++;
            $display("FAIL sra_neg: got r=%h lat=%0d, expected fffffff6 5", r, lat);
        end
        run_op(SRL, 32'hFFFFFF6E, 32'd4, lat, r, z, il);
        checks++;
        if (r !== 32'h0FFFFFF6 || lat !== 5) begin
            errors++;
            $display("FAIL srl: got r=%h lat=%0d, expected 0ffffff6 5", r, lat);
        end
        run_op(SRA, 32'd146, 32'h24, lat, r, z, il);
        checks++;
        if (r !== 32'd9 || lat !== 5) begin
            errors++;
            $display("FAIL sra_pos: got r=%h lat=%0d, expected 00000009 5", r, lat);
        end
        run_op(SLL, 32'h1234_5678, 32'h0, lat, r, z, il);
        checks++;
        if (r !== 32'h1234_5678 || lat !== 1) begin
            errors++;
            $display("FAIL sll_0: got r=%h lat=%0d, expected 12345678 1", r, lat);
        end
        run_op(SLL, 32'h3, 32'd31, lat, r, z, il);
        checks++;
        if (r !== 32'h8000_0000 || lat !== 32) begin
            errors++;
            $display("FAIL sll_31: got r=%h lat=%0d, expected 80000000 32", r, lat);
        end
    endtask

    task automatic test_step4();
        int lat;
        logic [3:0]  ops [2] = '{SRA, SRL};
        logic [31:0] as  [2] = '{32'h8000_0000, 32'h0000_0100};
        logic [31:0] bs  [2] = '{32'd31, 32'd5};
        logic [31:0] exr [2] = '{32'hFFFF_FFFF, 32'h0000_0008};
        int          exl [2] = '{9, 3};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            op = ops[i]; a = as[i]; b = bs[i]; v4 = 1'b1;
            @(posedge clk); #1;
            v4 = 1'b0;
            lat = 1;
            while (!out_valid4 && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            if (!out_valid4) lat = -1;
            checks++;
            if (result4 !== exr[i] || lat !== exl[i]) begin
                errors++;
                $display("FAIL step4_%0d: got r=%h lat=%0d, expected %h %0d",
                         i, result4, lat, exr[i], exl[i]);
            end
            rdy4 = 1'b1;
            @(posedge clk); #1;
            rdy4 = 1'b0;
        end
    endtask

    task automatic test_mul();
        int lat; logic [31:0] r; logic z, il;
        run_op(MUL, 32'd7, 32'hFFFFFFFD, lat, r, z, il);
`ifdef ITERATIVE_ALU_MUL_EN
        checks++;
        if (r !== 32'hFFFFFFEB || il !== 1'b0 || lat !== 33) begin
            errors++;
            $display("FAIL mul: got r=%h il=%b lat=%0d, expected ffffffeb 0 33", r, il, lat);
        end
`else
        checks++;
        if (r !== 32'h0 || il !== 1'b1 || lat !== 1) begin
            errors++;
            $display("FAIL mul_off: got r=%h il=%b lat=%0d, expected 0 1 1", r, il, lat);
        end
`endif
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        op = ADD; a = 32'd3; b = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        op = SUB; a = 32'd100; b = 32'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd7 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got ov=%b r=%h rdy=%b, expected 1 7 0",
                         i, out_valid, result, in_ready);
            end
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd7) begin
            errors++;
            n++;
            $display("FAIL bp_release: got ov=%b rdy=%b r=%h, expected 0 1 7",
                     out_valid, in_ready, result);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] r; logic z, il;
        @(negedge clk);
`ifdef ITERATIVE_ALU_MUL_EN
        op = MUL; a = 32'd7; b = 32'hFFFFFFFD;
`else
        op = SLL; a = 32'd1; b = 32'd31;
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got ov=%b r=%h rdy=%b z=%b, expected 0 0 0 0",
                     out_valid, result, in_ready, zero);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: got rdy=%b ov=%b, expected 1 0", in_ready, out_valid);
        end
        run_op(SLT, 32'hFFFFFFFF, 32'd1, lat, r, z, il);
        checks++;
        if (r !== 32'd1 || lat !== 1) begin
            errors++;
            $display("FAIL slt_neg: got r=%h lat=%0d, expected 1 1", r, lat);
        end
        run_op(SLT, 32'd1, 32'hFFFFFFFF, lat, r, z, il);
        checks++;
        if (r !== 32'd0 || z !== 1'b1) begin
            errors++;
            $display("FAIL slt_pos: got r=%h z=%b, expected 0 1", r, z);
        end
        run_op(4'b1111, 32'h55, 32'h66, lat, r, z, il);
        checks++;
        if (r !== 32'h0 || il !== 1'b1 || lat !== 1) begin
            errors++;
            $display("FAIL illegal: got r=%h il=%b lat=%0d, expected 0 1 1", r, il, lat);
        end
        run_op(ADD, 32'd1, 32'd1, lat, r, z, il);
        checks++;
        if (r !== 32'd2 || il !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: got r=%h il=%b, expected 2 0", r, il);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift();
        test_step4();
        test_mul();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Parametrised multi-cycle ALU, successor to the single-cycle datapath ALU; sits between register-file read and writeback in the multi-cycle core.
- Single-cycle ops (add/sub/and/or/slt) plus iterative shifts (sll/srl/sra), stepping SHIFT_STEP bits per cycle.
- Optional shift-add multiplier.
- Valid/ready handshakes on both sides, so the controller can stall on long operations.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8.
- SHIFT_STEP, 1, bits shifted per BUSY cycle; power of two, 1..XLEN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- op  in  4  opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 SLT, 0110 SLL, 0111 SRL, 0100 SRA, 1000 MUL; all others illegal.
- a  in  XLEN  operand A.
- b  in  XLEN  operand B; for shifts, shift amount = b[log2(XLEN)-1:0], upper bits ignored.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  result.
- zero  out  1  result == 0.
- illegal  out  1  completed op was illegal.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (rst=0, async): state=IDLE; in_ready=0 while rst=0; out_valid=0, result=0, zero=0 (result is 0 but zero is forced 0 until the first completion), illegal=0; internal counters/accumulators cleared.
- in_ready = 1 only in IDLE.
- Accept = in_valid & in_ready at a rising edge; a, b, op are captured at that edge. Inputs are don't-care at all other times.
- On accept:
  - ADD/SUB/AND/OR/SLT: compute, go to DONE.
  - Illegal op: result=0, illegal=1, go to DONE.
  - Shift with shamt=0: result=a, go to DONE.
  - Shift with shamt>0: load a, remaining=shamt, go to BUSY.
  - MUL: clear accumulator, load multiplicand and multiplier, go to BUSY.
- BUSY, shifts: each edge shifts by s=min(SHIFT_STEP, remaining) and decrements remaining by s. SRA fills with the operand MSB; SLL/SRL fill with 0. When remaining reaches 0, go to DONE.
- BUSY, MUL: radix-2 shift-add for exactly XLEN edges. Result = low XLEN bits of a*b (identical for signed and unsigned).
- Latency, accept cycle to first out_valid cycle = 1+k:
  - k=0 for single-cycle, illegal and shamt=0 ops;
  - k=ceil(shamt/SHIFT_STEP) for shifts;
  - k=XLEN for MUL.
- DONE: out_valid=1; result/zero/illegal stable until the handshake. Edge with out_ready=1 returns to IDLE and clears out_valid. No same-cycle accept; next accept is possible one cycle later.
- out_ready is ignored outside DONE.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN, no carry/overflow outputs.
  - SLT is a signed compare: result = {0..0, (a-b) sign-corrected for overflow}.
- zero and illegal update only when entering DONE.
- Reset mid-operation (BUSY or DONE) aborts immediately; partial results are discarded.

Optional Feature:
- Macro: ITERATIVE_ALU_MUL_EN.
- Defined: MUL (1000) implemented as above.
- Undefined: no multiplier datapath is synthesised; MUL is treated as illegal (1-cycle, result=0, illegal=1).

Test Plan:
- XLEN=32, STEP=1: ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, zero=0, out_valid 1 cycle after accept; SUB a=5, b=5 -> result 0, zero=1.
- SRA a=0xFFFFFF6E, b=4 -> 0xFFFFFFF6 at latency 5; SRL same operands -> 0x0FFFFFF6; SRA a=146, b=0x24 (shamt 4) -> 9; SLL b=0 -> a, latency 1.
- SHIFT_STEP=4: SRA a=0x80000000, b=31 -> 0xFFFFFFFF at latency 1+8=9.
- MUL (macro defined) a=7, b=0xFFFFFFFD -> 0xFFFFFFEB at latency 33. Macro undefined: same request -> result 0, illegal=1, latency 1.
- Backpressure: out_ready=0 for 3 cycles in DONE -> result held, out_valid=1, in_ready=0, a new in_valid ignored; out_ready=1 -> IDLE next cycle.
- rst pulled low mid-MUL (cycle 10 of BUSY) -> out_valid=0, result=0, in_ready=0 asynchronously; after release, SLT a=0xFFFFFFFF, b=1 -> 1 at latency 1; op=1111 -> illegal=1, result=0.
